// File: rtl/vga_beam_compositor_pkg.sv
// vga_pkg: shared types and default 1024x768 timing for the beam compositor.
//   color_t  - 12-bit RGB, one nibble per channel, index with R/G/B
//   tim_t    - per-pixel timing flags carried down the alignment pipe
package vga_pkg;

    typedef logic [2:0][3:0] color_t;

    localparam int R = 2;
    localparam int G = 1;
    localparam int B = 0;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } tim_t;

    localparam int DEF_H_VISIBLE = 1024;
    localparam int DEF_H_FRONT   = 24;
    localparam int DEF_H_SYNC    = 136;
    localparam int DEF_H_BACK    = 160;
    localparam int DEF_V_VISIBLE = 768;
    localparam int DEF_V_FRONT   = 3;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 29;

endpackage

// File: rtl/vga_beam_compositor_if.sv
// Beam/layer bus. The compositor (master) publishes the beam position; the
// layers (slave) answer with a registered colour and transparency flag.
//   beam_x, beam_y     - current raster counters
//   layer_color        - per-layer RGB, index 0 = highest priority
//   layer_transparent  - per-layer pass-through flag
interface vga_beam_compositor_if #(
    parameter int LAYERS = 4
);
    import vga_pkg::*;

    logic [10:0]              beam_x;
    logic [9:0]               beam_y;
    color_t [LAYERS-1:0]      layer_color;
    logic   [LAYERS-1:0]      layer_transparent;

    modport master (output beam_x, beam_y, input layer_color, layer_transparent);
    modport slave  (input beam_x, beam_y, output layer_color, layer_transparent);

endinterface

// File: rtl/vga_beam_compositor_timing.sv
// vga_timing: raster counters, raw visible/sync decode and frame pacing.
//   clk, rst           - pixel clock, async active-low reset
//   beam_x_o, beam_y_o - counter registers (no logic after the flops)
//   visible_o, hs_act_o, vs_act_o - raw decode of the current position
//   frame_tick_o       - one-cycle pulse after the beam reaches (0, V_VISIBLE)
//   frame_count_o      - frames completed, free-running 16-bit
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] beam_x_o,
    output logic [9:0]  beam_y_o,
    output logic        visible_o,
    output logic        hs_act_o,
    output logic        vs_act_o,
    output logic        frame_tick_o,
    output logic [15:0] frame_count_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 2048) begin : g_h_range
        $error("vga_timing: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_v_range
        $error("vga_timing: V_TOTAL exceeds 1024");
    end

    // Decode bounds are one bit wider than the counters so a sync window
    // ending exactly at 2048/1024 does not wrap to zero.
    localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [11:0] X_VIS  = 12'(H_VISIBLE);
    localparam logic [11:0] HS_ON  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_OFF = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] Y_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        tick_q, tick_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        x_d    = x_q + 11'd1;
        y_d    = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
        end
        tick_d = (x_q == '0) && ({1'b0, y_q} == Y_VIS);
        cnt_d  = cnt_q + 16'(tick_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
        end
    end

    assign beam_x_o      = x_q;
    assign beam_y_o      = y_q;
    assign frame_tick_o  = tick_q;
    assign frame_count_o = cnt_q;

    assign visible_o = ({1'b0, x_q} < X_VIS) && ({1'b0, y_q} < Y_VIS);
    assign hs_act_o  = ({1'b0, x_q} >= HS_ON) && ({1'b0, x_q} < HS_OFF);
    assign vs_act_o  = ({1'b0, y_q} >= VS_ON) && ({1'b0, y_q} < VS_OFF);

endmodule

// File: rtl/vga_beam_compositor.sv
// vga_beam_compositor: raster generator plus layer priority compositor.
//   clk, rst        - pixel clock, async active-low reset
//   bus (master)    - beam position out, layer colour/transparency in
//   vga_r/g/b       - composited pixel, zero outside the visible area
//   vga_hs/vs/de    - syncs and data-enable, aligned with RGB
//   frame_tick      - pulse at start of vertical blank (not pipelined)
//   frame_count     - frames completed
module vga_beam_compositor
    import vga_pkg::*;
#(
    parameter int     H_VISIBLE       = DEF_H_VISIBLE,
    parameter int     H_FRONT         = DEF_H_FRONT,
    parameter int     H_SYNC          = DEF_H_SYNC,
    parameter int     H_BACK          = DEF_H_BACK,
    parameter int     V_VISIBLE       = DEF_V_VISIBLE,
    parameter int     V_FRONT         = DEF_V_FRONT,
    parameter int     V_SYNC          = DEF_V_SYNC,
    parameter int     V_BACK          = DEF_V_BACK,
    parameter bit     SYNC_ACTIVE_LOW = 1'b1,
    parameter int     LAYERS          = 4,
    parameter int     LAYER_LATENCY   = 1,
    parameter color_t BG_COLOR        = 12'hFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_beam_compositor_if.master  bus,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_de,
    output logic                   frame_tick,
    output logic [15:0]            frame_count
);

    if (LAYER_LATENCY < 1) begin : g_lat_range
        $error("vga_beam_compositor: LAYER_LATENCY must be at least 1");
    end

    tim_t raw;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .beam_x_o      (bus.beam_x),
        .beam_y_o      (bus.beam_y),
        .visible_o     (raw.vis),
        .hs_act_o      (raw.hs),
        .vs_act_o      (raw.vs),
        .frame_tick_o  (frame_tick),
        .frame_count_o (frame_count)
    );

    // Timing flags wait here for the layers to answer the same beam position.
    tim_t [LAYER_LATENCY-1:0] dly_q;
    tim_t                     tim;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly_q <= '0;
        end else begin
            dly_q[0] <= raw;
            for (int i = 1; i < LAYER_LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign tim = dly_q[LAYER_LATENCY-1];

    // Walk from lowest to highest priority so the lowest opaque index wins.
    color_t win;
    always_comb begin
        win = BG_COLOR;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (!bus.layer_transparent[i]) win = bus.layer_color[i];
        end
    end

    color_t rgb_q, rgb_d;
    logic   de_q, hs_q, vs_q;

    // Blanking selects a constant, so undefined layer data cannot leak out.
    assign rgb_d = tim.vis ? win : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= SYNC_ACTIVE_LOW;
            vs_q  <= SYNC_ACTIVE_LOW;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= tim.vis;
            hs_q  <= tim.hs ^ SYNC_ACTIVE_LOW;
            vs_q  <= tim.vs ^ SYNC_ACTIVE_LOW;
        end
    end

    assign vga_r  = rgb_q[R];
    assign vga_g  = rgb_q[G];
    assign vga_b  = rgb_q[B];
    assign vga_de = de_q;
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_beam_compositor.sv
// Self-checking bench for vga_beam_compositor on a reduced raster so that
// whole frames fit in a short run. A registered layer model answers the beam;
// a per-cycle scoreboard predicts every output two clocks ahead.
module tb_vga_beam_compositor;
    import vga_pkg::*;

    localparam int HV = 32, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 12, VF = 1, VS = 2, VB = 2, VT = VV + VF + VS + VB;
    localparam int SX = 20, SY = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_beam_compositor_if #(.LAYERS(4)) bus ();

    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, frame_tick;
    logic [15:0] frame_count;

    vga_beam_compositor #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_ACTIVE_LOW (1'b1), .LAYERS (4), .LAYER_LATENCY (1), .BG_COLOR (12'hFFF)
    ) dut (
        .clk (clk), .rst (rst), .bus (bus.master),
        .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
        .vga_hs (vga_hs), .vga_vs (vga_vs), .vga_de (vga_de),
        .frame_tick (frame_tick), .frame_count (frame_count)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } out_t;

    typedef struct {
        logic [3:0][11:0] col;
        logic [3:0]       tr;
        logic [11:0]      exp;
    } vec_t;

    int               checks = 0, errors = 0;
    int               mode = 0;
    logic [3:0][11:0] cfg_col = '0;
    logic [3:0]       cfg_tr = 4'hF;
    int               mx, my, m_cnt;
    logic             m_tick;
    int               spot_hits, de_cnt, hs_lo, vs_lo;
    out_t             sb_q[$];
    vec_t             vt[6];

    // Layer response {transparent, colour} for beam (x,y). Mode 0: static
    // config; mode 1: a single opaque 123 pixel; mode 2: opaque white in the
    // visible area, random garbage in blanking.
    function automatic logic [12:0] layer_resp(int md, int x, int y, int i);
        if (md == 0) return {cfg_tr[i], cfg_col[i]};
        if (md == 1) return (i == 0 && x == SX && y == SY) ? {1'b0, 12'h123} : {1'b1, 12'($urandom)};
        return (x < HV && y < VV) ? {1'b0, 12'hFFF} : 13'($urandom);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            {bus.layer_transparent[i], bus.layer_color[i]} <= layer_resp(mode, int'(bus.beam_x), int'(bus.beam_y), i);
    end

    function automatic out_t expect_at(int x, int y);
        out_t o;
        logic [12:0] r;
        logic found;
        o.de  = (x < HV) && (y < VV);
        o.hs  = !((x >= HV + HF) && (x < HV + HF + HS));
        o.vs  = !((y >= VV + VF) && (y < VV + VF + VS));
        o.rgb = 12'h000;
        if (o.de) begin
            o.rgb = 12'hFFF;
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                r = layer_resp(mode, x, y, i);
                if (!found && !r[12]) begin
                    o.rgb = r[11:0];
                    found = 1'b1;
                end
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (model x=%0d y=%0d)", name, act, exp, mx, my);
        end
    endtask

    task automatic sb_reset();
        sb_q.delete();
        sb_q.push_back(out_t'({12'h000, 1'b0, 1'b1, 1'b1}));
        sb_q.push_back(out_t'({12'h000, 1'b0, 1'b1, 1'b1}));
        mx = 0; my = 0; m_cnt = 0; m_tick = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {bus.beam_x, bus.beam_y, vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, frame_tick, frame_count},
                    {11'd0, 10'd0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
    endtask

    // Called just after a falling edge: compare this cycle, then advance.
    task automatic step();
        out_t got;
        check("beam", {bus.beam_x, bus.beam_y}, {11'(mx), 10'(my)});
        check("tick", {frame_tick, frame_count}, {m_tick, 16'(m_cnt)});
        sb_q.push_back(expect_at(mx, my));
        got = {vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs};
        check("pixel", got, sb_q.pop_front());
        if (got.de && got.rgb == 12'h123) spot_hits++;
        de_cnt += int'(got.de);
        hs_lo  += int'(!got.hs);
        vs_lo  += int'(!got.vs);
        @(negedge clk);
        m_tick = (mx == 0 && my == VV);
        if (m_tick) m_cnt = (m_cnt + 1) % 65536;
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    initial begin
        int seen;
        int guard;
        vt[0] = '{col: {12'h00F, 12'h0F0, 12'hF00, 12'h000}, tr: 4'b0001, exp: 12'hF00};
        vt[1] = '{col: {12'h00F, 12'h0F0, 12'hF00, 12'h000}, tr: 4'b1111, exp: 12'hFFF};
        vt[2] = '{col: {12'h333, 12'h222, 12'h111, 12'h00A}, tr: 4'b0000, exp: 12'h00A};
        vt[3] = '{col: {12'h555, 12'h0F0, 12'hF00, 12'hABC}, tr: 4'b0011, exp: 12'h0F0};
        vt[4] = '{col: {12'h555, 12'h0F0, 12'hF00, 12'hABC}, tr: 4'b0111, exp: 12'h555};
        vt[5] = '{col: {12'h555, 12'h0F0, 12'hF00, 12'hABC}, tr: 4'b1110, exp: 12'hABC};

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_state");
        sb_reset();
        rst = 1'b1;

        // Priority vectors, each applied inside the visible part of a line.
        for (int v = 0; v < 6; v++) begin
            guard = 0;
            while (!(mx < HV - 4 && my < VV) && guard < HT * VT) begin
                step();
                guard++;
            end
            cfg_col = vt[v].col;
            cfg_tr  = vt[v].tr;
            repeat (3) step();
            check($sformatf("prio%0d", v), {vga_de, vga_r, vga_g, vga_b}, {1'b1, vt[v].exp});
        end

        // Single-pixel latency probe across one full frame and its wrap.
        mode = 1;
        spot_hits = 0;
        repeat (HT * VT + 5) step();
        check("spot_hits", spot_hits, 1);
        check("frame_count_1", frame_count, 16'd1);

        // Opaque white with garbage in blanking: per-frame strobe/sync totals.
        mode = 2;
        de_cnt = 0; hs_lo = 0; vs_lo = 0;
        repeat (HT * VT) step();
        check("de_per_frame", de_cnt, HV * VV);
        check("hs_low_per_frame", hs_lo, HS * VT);
        check("vs_low_per_frame", vs_lo, VS * HT);

        // Asynchronous reset between edges, mid-frame.
        guard = 0;
        while (!(mx == 20 && my == 5) && guard < HT * VT) begin
            step();
            guard++;
        end
        #2 rst = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        check_reset_vals("reset_held");
        sb_reset();
        rst = 1'b1;

        seen = -1;
        for (int n = 0; n < HT * VT; n++) begin
            if (frame_tick) begin
                seen = n;
                break;
            end
            step();
        end
        check("tick_after_reset", seen, VV * HT + 1);
        repeat (HT * 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
